// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction fetch stage with an in-order instruction queue.
//
// Issues in-order fetch requests on an SRAM-like bus, keeping at most
// MAX_OUTSTANDING accepted-but-unanswered requests in flight. Responses land
// in an IBUF_DEPTH-entry queue that feeds ID. A redirect (exception, ertn or
// resolved branch) flushes the queue. Responses still owed for requests that
// were issued before the redirect are counted in cancel_cnt and dropped when
// they arrive.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   inst_sram_*                  SRAM-like instruction bus (read-only use)
//   wb_ex / csr_ex_entry         exception redirect and target
//   ertn_flush / csr_ertn_entry  ertn redirect and target
//   br_taken / br_stall / br_target  branch redirect from ID; br_stall blocks
//                                issue and masks br_taken
//   ds_allowin                   ID can accept the head entry
//   fs2ds_valid / fs2ds_bus      head entry {adef, pc, inst}
//   fs_inflight                  live plus cancelled requests in flight
module fetch_queue_stage #(
   parameter logic [31:0] RESET_PC        = 32'h1c000000,
   parameter int unsigned IBUF_DEPTH      = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   output logic                                 inst_sram_req,
   output logic                                 inst_sram_wr,
   output logic [1:0]                           inst_sram_size,
   output logic [3:0]                           inst_sram_wstrb,
   output logic [31:0]                          inst_sram_addr,
   output logic [31:0]                          inst_sram_wdata,
   input  logic                                 inst_sram_addr_ok,
   input  logic                                 inst_sram_data_ok,
   input  logic [31:0]                          inst_sram_rdata,
   input  logic                                 wb_ex,
   input  logic [31:0]                          csr_ex_entry,
   input  logic                                 ertn_flush,
   input  logic [31:0]                          csr_ertn_entry,
   input  logic                                 br_taken,
   input  logic                                 br_stall,
   input  logic [31:0]                          br_target,
   input  logic                                 ds_allowin,
   output logic                                 fs2ds_valid,
   output logic [64:0]                          fs2ds_bus,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] fs_inflight
);

   localparam int unsigned PW = $clog2(IBUF_DEPTH);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]   fetch_pc;
   logic          halt;
   logic [CW-1:0] cancel_cnt;
   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [PW:0]   head, fill, tail;

   logic [31:0]   q_pc     [IBUF_DEPTH];
   logic [31:0]   q_inst   [IBUF_DEPTH];
   logic          q_adef   [IBUF_DEPTH];
   logic          q_filled [IBUF_DEPTH];

   logic          flush;
   logic [31:0]   target;
   logic [PW:0]   count;
   logic [PW:0]   pending;
   logic          credit_ok;
   logic          can_fetch;
   logic          aligned;
   logic          alloc;
   logic          adef_alloc;
   logic          resp_live;
   logic          resp_cancel;
   logic          pop;
   logic [PW-1:0] head_idx, fill_idx, tail_idx;

   always_comb begin
      flush     = wb_ex | ertn_flush | (br_taken & ~br_stall);
      target    = wb_ex ? csr_ex_entry : (ertn_flush ? csr_ertn_entry : br_target);
      count     = tail - head;
      pending   = tail - fill;
      head_idx  = head[PW-1:0];
      fill_idx  = fill[PW-1:0];
      tail_idx  = tail[PW-1:0];
      credit_ok = (32'(pending) + 32'(cancel_cnt)) < MAX_OUTSTANDING;
      can_fetch = ~flush & ~br_stall & ~halt & (32'(count) < IBUF_DEPTH) & credit_ok;
      aligned   = (fetch_pc[1:0] == 2'b00);

      inst_sram_req   = can_fetch & aligned & ~reset;
      inst_sram_addr  = inst_sram_req ? fetch_pc : 32'h0;
      inst_sram_wr    = 1'b0;
      inst_sram_size  = 2'b10;
      inst_sram_wstrb = 4'h0;
      inst_sram_wdata = 32'h0;

      alloc       = inst_sram_req & inst_sram_addr_ok;
      // Misaligned PC becomes a filled adef entry; waiting for pending == 0
      // keeps fill pointing past it so responses never overwrite it.
      adef_alloc  = can_fetch & ~aligned & (pending == '0);
      resp_live   = inst_sram_data_ok & (cancel_cnt == '0) & (fill != tail) & ~flush;
      resp_cancel = inst_sram_data_ok & (cancel_cnt != '0) & ~flush;

      fs2ds_valid = q_filled[head_idx] & (count != '0) & ~flush;
      fs2ds_bus   = {q_adef[head_idx], q_pc[head_idx], q_inst[head_idx]};
      pop         = fs2ds_valid & ds_allowin;
      fs_inflight = CW'(pending) + cancel_cnt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc   <= RESET_PC;
         halt       <= 1'b0;
         cancel_cnt <= '0;
         head       <= '0;
         fill       <= '0;
         tail       <= '0;
         for (int i = 0; i < IBUF_DEPTH; i++) begin
            q_pc[i]     <= 32'h0;
            q_inst[i]   <= 32'h0;
            q_adef[i]   <= 1'b0;
            q_filled[i] <= 1'b0;
         end
      end else if (flush) begin
         fetch_pc   <= target;
         halt       <= 1'b0;
         head       <= '0;
         fill       <= '0;
         tail       <= '0;
         // Every unanswered request becomes a cancelled one; a response in
         // this cycle retires one of them.
         cancel_cnt <= cancel_cnt + CW'(pending) - CW'(inst_sram_data_ok);
      end else begin
         if (alloc) begin
            q_pc[tail_idx]     <= fetch_pc;
            q_adef[tail_idx]   <= 1'b0;
            q_filled[tail_idx] <= 1'b0;
            tail               <= tail + 1'b1;
            fetch_pc           <= fetch_pc + 32'd4;
         end else if (adef_alloc) begin
            q_pc[tail_idx]     <= fetch_pc;
            q_inst[tail_idx]   <= 32'h0;
            q_adef[tail_idx]   <= 1'b1;
            q_filled[tail_idx] <= 1'b1;
            tail               <= tail + 1'b1;
            fill               <= fill + 1'b1;
            halt               <= 1'b1;
         end
         if (resp_live) begin
            q_inst[fill_idx]   <= inst_sram_rdata;
            q_filled[fill_idx] <= 1'b1;
            fill               <= fill + 1'b1;
         end
         if (resp_cancel) begin
            cancel_cnt <= cancel_cnt - 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
      end
   end

   // A response with nothing cancelled and no allocated unfilled slot means
   // the bus answered a request that was never accepted.
   a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
      !(inst_sram_data_ok && (cancel_cnt == '0) && (fill == tail)));

endmodule
